// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for the systolic array: issues per-beat buffer reads and
// models the array's fixed latency so output-buffer writes line up with results.
module systolic_array_ctrl #(
  parameter int IBUF_ADDR_WIDTH = 16,
  parameter int WBUF_ADDR_WIDTH = 16,
  parameter int BBUF_ADDR_WIDTH = 16,
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int SA_LATENCY      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       cfg_rows,
  input  logic [CNT_WIDTH-1:0]       cfg_loops,
  input  logic                       cfg_bias_en,
  input  logic [IBUF_ADDR_WIDTH-1:0] cfg_ibuf_base,
  input  logic [WBUF_ADDR_WIDTH-1:0] cfg_wbuf_base,
  input  logic [BBUF_ADDR_WIDTH-1:0] cfg_bias_base,
  input  logic [OBUF_ADDR_WIDTH-1:0] cfg_obuf_base,
  input  logic                       stall,
  output logic                       busy,
  output logic                       done,
  output logic                       ibuf_read_req,
  output logic [IBUF_ADDR_WIDTH-1:0] ibuf_read_addr,
  output logic                       wbuf_read_req,
  output logic [WBUF_ADDR_WIDTH-1:0] wbuf_read_addr,
  output logic                       bias_read_req,
  output logic [BBUF_ADDR_WIDTH-1:0] bias_read_addr,
  output logic                       bias_prev_sw,
  output logic                       acc_clear,
  output logic                       obuf_read_req,
  output logic [OBUF_ADDR_WIDTH-1:0] obuf_read_addr,
  output logic                       obuf_write_req,
  output logic [OBUF_ADDR_WIDTH-1:0] obuf_write_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_LOOP_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0]       CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]       LAT_CNT    = CNT_WIDTH'(SA_LATENCY);
  localparam logic [IBUF_ADDR_WIDTH-1:0] IBUF_ONE   = IBUF_ADDR_WIDTH'(1);
  // Every stage except the output stage; empty here means the pipe is empty after this edge.
  localparam logic [SA_LATENCY-1:0]      EARLY_MASK = {SA_LATENCY{1'b1}} >> 1;

  state_t state_reg, state_next;

  logic [CNT_WIDTH-1:0]       rows_reg, loops_reg;
  logic                       bias_en_reg;
  logic [WBUF_ADDR_WIDTH-1:0] wbuf_base_reg;
  logic [BBUF_ADDR_WIDTH-1:0] bias_base_reg;
  logic [OBUF_ADDR_WIDTH-1:0] obuf_base_reg;
  logic [CNT_WIDTH-1:0]       row_reg, loop_reg;
  logic [IBUF_ADDR_WIDTH-1:0] ibuf_ptr_reg;

  logic [SA_LATENCY-1:0]      sr_valid_reg;
  logic [OBUF_ADDR_WIDTH-1:0] sr_addr_reg [SA_LATENCY];

  logic                       beat;
  logic                       row_last;
  logic                       loop_last;
  logic                       pipe_clear_next;
  logic [OBUF_ADDR_WIDTH-1:0] beat_obuf_addr;

  assign beat            = (state_reg == S_COMPUTE) && !stall;
  assign row_last        = (row_reg == rows_reg - CNT_ONE);
  assign loop_last       = (loop_reg == loops_reg - CNT_ONE);
  assign pipe_clear_next = ~|(sr_valid_reg & EARLY_MASK);
  assign beat_obuf_addr  = obuf_base_reg + OBUF_ADDR_WIDTH'(row_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if ((cfg_rows == '0) || (cfg_loops == '0)) state_next = S_DONE;
          else                                      state_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (beat && row_last) begin
          if (loop_last)               state_next = S_DRAIN;
          // Short loops must wait so the next loop's partial-sum reads see the writes.
          else if (rows_reg < LAT_CNT) state_next = S_LOOP_WAIT;
        end
      end
      S_LOOP_WAIT: if (pipe_clear_next) state_next = S_COMPUTE;
      S_DRAIN:     if (pipe_clear_next) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_reg      <= '0;
      loops_reg     <= '0;
      bias_en_reg   <= 1'b0;
      wbuf_base_reg <= '0;
      bias_base_reg <= '0;
      obuf_base_reg <= '0;
      row_reg       <= '0;
      loop_reg      <= '0;
      ibuf_ptr_reg  <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      rows_reg      <= cfg_rows;
      loops_reg     <= cfg_loops;
      bias_en_reg   <= cfg_bias_en;
      wbuf_base_reg <= cfg_wbuf_base;
      bias_base_reg <= cfg_bias_base;
      obuf_base_reg <= cfg_obuf_base;
      row_reg       <= '0;
      loop_reg      <= '0;
      ibuf_ptr_reg  <= cfg_ibuf_base;
    end else if (beat) begin
      ibuf_ptr_reg <= ibuf_ptr_reg + IBUF_ONE;
      if (row_last) begin
        row_reg  <= '0;
        loop_reg <= loop_reg + CNT_ONE;
      end else begin
        row_reg <= row_reg + CNT_ONE;
      end
    end
  end

  // Latency model: one stage per array cycle, output stage drives the write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_valid_reg <= '0;
      for (int i = 0; i < SA_LATENCY; i++) sr_addr_reg[i] <= '0;
    end else begin
      sr_valid_reg[0] <= beat;
      sr_addr_reg[0]  <= beat ? beat_obuf_addr : '0;
      for (int i = 1; i < SA_LATENCY; i++) begin
        sr_valid_reg[i] <= sr_valid_reg[i-1];
        sr_addr_reg[i]  <= sr_addr_reg[i-1];
      end
    end
  end

  always_comb begin
    ibuf_read_req  = 1'b0;
    ibuf_read_addr = '0;
    wbuf_read_req  = 1'b0;
    wbuf_read_addr = '0;
    bias_read_req  = 1'b0;
    bias_read_addr = '0;
    bias_prev_sw   = 1'b0;
    acc_clear      = 1'b0;
    obuf_read_req  = 1'b0;
    obuf_read_addr = '0;
    if (beat) begin
      ibuf_read_req  = 1'b1;
      ibuf_read_addr = ibuf_ptr_reg;
      wbuf_read_req  = 1'b1;
      wbuf_read_addr = wbuf_base_reg + WBUF_ADDR_WIDTH'(loop_reg);
      if (loop_reg == '0) begin
        bias_prev_sw   = 1'b1;
        bias_read_req  = bias_en_reg;
        bias_read_addr = bias_base_reg;
        acc_clear      = !bias_en_reg;
      end else begin
        obuf_read_req  = 1'b1;
        obuf_read_addr = beat_obuf_addr;
      end
    end
  end

  assign busy            = (state_reg != S_IDLE);
  assign done            = (state_reg == S_DONE);
  assign obuf_write_req  = sr_valid_reg[SA_LATENCY-1];
  assign obuf_write_addr = sr_addr_reg[SA_LATENCY-1];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: a negedge monitor logs beats, writes and
// done pulses by cycle; each scenario then compares the logs to hand-derived timing.
module tb_systolic_array_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_rows, cfg_loops;
  logic        cfg_bias_en;
  logic [15:0] cfg_ibuf_base, cfg_wbuf_base, cfg_bias_base, cfg_obuf_base;
  logic        stall;
  logic        busy, done;
  logic        ibuf_read_req, wbuf_read_req, bias_read_req, obuf_read_req, obuf_write_req;
  logic [15:0] ibuf_read_addr, wbuf_read_addr, bias_read_addr, obuf_read_addr, obuf_write_addr;
  logic        bias_prev_sw, acc_clear;

  systolic_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_rows(cfg_rows), .cfg_loops(cfg_loops), .cfg_bias_en(cfg_bias_en),
    .cfg_ibuf_base(cfg_ibuf_base), .cfg_wbuf_base(cfg_wbuf_base),
    .cfg_bias_base(cfg_bias_base), .cfg_obuf_base(cfg_obuf_base),
    .stall(stall), .busy(busy), .done(done),
    .ibuf_read_req(ibuf_read_req), .ibuf_read_addr(ibuf_read_addr),
    .wbuf_read_req(wbuf_read_req), .wbuf_read_addr(wbuf_read_addr),
    .bias_read_req(bias_read_req), .bias_read_addr(bias_read_addr),
    .bias_prev_sw(bias_prev_sw), .acc_clear(acc_clear),
    .obuf_read_req(obuf_read_req), .obuf_read_addr(obuf_read_addr),
    .obuf_write_req(obuf_write_req), .obuf_write_addr(obuf_write_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [15:0] ia, wa, ba, oa;
    logic        br, ps, ac, orq;
  } beat_t;

  typedef struct {
    int          c;
    logic [15:0] a;
  } wr_t;

  int    cyc = 0;
  beat_t beats[$];
  wr_t   writes[$];
  int    dones[$];
  int    busy_cnt   = 0;
  int    stray_cnt  = 0;
  int    rst_active = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (ibuf_read_req)
      beats.push_back('{cyc, ibuf_read_addr, wbuf_read_addr, bias_read_addr, obuf_read_addr,
                        bias_read_req, bias_prev_sw, acc_clear, obuf_read_req});
    else if (wbuf_read_req | bias_read_req | obuf_read_req | acc_clear | bias_prev_sw)
      stray_cnt <= stray_cnt + 1;
    if (obuf_write_req) writes.push_back('{cyc, obuf_write_addr});
    if (done) dones.push_back(cyc);
    if (!reset && (busy | done | ibuf_read_req | wbuf_read_req | bias_read_req | bias_prev_sw |
                   acc_clear | obuf_read_req | obuf_write_req | (|obuf_write_addr) |
                   (|ibuf_read_addr) | (|wbuf_read_addr) | (|obuf_read_addr)))
      rst_active <= rst_active + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input int k, input int t, input int off, input int ia, input int wa,
                          input logic br, input logic ps, input logic ac, input logic orq,
                          input int oa);
    beat_t b;
    b = beats[k];
    chk($sformatf("beat%0d_cycle", k), b.c - t, off);
    chk($sformatf("beat%0d_ibuf", k), {16'h0, b.ia}, ia);
    chk($sformatf("beat%0d_wbuf", k), {16'h0, b.wa}, wa);
    chk($sformatf("beat%0d_bias_req", k), {31'h0, b.br}, {31'h0, br});
    chk($sformatf("beat%0d_prev_sw", k), {31'h0, b.ps}, {31'h0, ps});
    chk($sformatf("beat%0d_acc_clear", k), {31'h0, b.ac}, {31'h0, ac});
    chk($sformatf("beat%0d_obuf_rreq", k), {31'h0, b.orq}, {31'h0, orq});
    if (br) chk($sformatf("beat%0d_bias_addr", k), {16'h0, b.ba}, 32'h30);
    if (orq) chk($sformatf("beat%0d_obuf_raddr", k), {16'h0, b.oa}, oa);
  endtask

  task automatic chk_wr(input int k, input int t, input int off, input int a);
    chk($sformatf("write%0d_cycle", k), writes[k].c - t, off);
    chk($sformatf("write%0d_addr", k), {16'h0, writes[k].a}, a);
  endtask

  // Launches a tile at cycle t and runs n further cycles; stall, a second start,
  // and a 2-cycle reset pulse are placed at offsets relative to t (1000 = never).
  task automatic run_tile(input int rows, input int loops, input logic bias,
                          input int stall_from, input int stall_n, input int restart_at,
                          input int rst_at, input int n, output int t);
    @(posedge clk); #1;
    cfg_rows    = 16'(rows);
    cfg_loops   = 16'(loops);
    cfg_bias_en = bias;
    start       = 1'b1;
    t           = cyc;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      stall = (c >= stall_from) && (c < stall_from + stall_n);
      reset = !((c >= rst_at) && (c < rst_at + 2));
    end
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    $display("tile rows=%0d loops=%0d bias_en=%0d start_cycle=%0d", rows, loops, bias, t);
  endtask

  int t, nb, nw, nd, bc, sc, ra;
  int offs[4];

  task automatic mark();
    nb = beats.size(); nw = writes.size(); nd = dones.size();
    bc = busy_cnt; sc = stray_cnt; ra = rst_active;
  endtask

  // Basic 4-row, 1-loop, bias-enabled tile; reused after the mid-tile reset.
  task automatic check_scenario1(input string s);
    chk({s, "_beats"}, beats.size() - nb, 4);
    chk({s, "_writes"}, writes.size() - nw, 4);
    chk({s, "_dones"}, dones.size() - nd, 1);
    if (beats.size() - nb == 4)
      for (int i = 0; i < 4; i++)
        chk_beat(nb + i, t, i + 1, 'h10 + i, 'h20, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    if (writes.size() - nw == 4)
      for (int i = 0; i < 4; i++) chk_wr(nw + i, t, 9 + i, 'h40 + i);
    if (dones.size() - nd == 1) chk({s, "_done_cycle"}, dones[nd] - t, 13);
    chk({s, "_busy_cycles"}, busy_cnt - bc, 13);
    chk({s, "_stray"}, stray_cnt - sc, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    cfg_rows = '0; cfg_loops = '0; cfg_bias_en = 1'b0;
    cfg_ibuf_base = 16'h10; cfg_wbuf_base = 16'h20;
    cfg_bias_base = 16'h30; cfg_obuf_base = 16'h40;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_ibuf_req", {31'h0, ibuf_read_req}, 0);
    chk("rst_wbuf_req", {31'h0, wbuf_read_req}, 0);
    chk("rst_obuf_wreq", {31'h0, obuf_write_req}, 0);
    chk("rst_obuf_waddr", {16'h0, obuf_write_addr}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", {31'h0, busy}, 0);

    // Scenario 1: R=4 L=1 bias on
    mark();
    run_tile(4, 1, 1'b1, 1000, 0, 1000, 1000, 20, t);
    check_scenario1("s1");

    // Scenario 2: R=16 L=3 bias off
    mark();
    run_tile(16, 3, 1'b0, 1000, 0, 1000, 1000, 65, t);
    chk("s2_beats", beats.size() - nb, 48);
    chk("s2_writes", writes.size() - nw, 48);
    chk("s2_dones", dones.size() - nd, 1);
    if (beats.size() - nb == 48)
      for (int k = 0; k < 48; k++)
        chk_beat(nb + k, t, k + 1, 'h10 + k, 'h20 + k / 16, 1'b0, k < 16, k < 16, k >= 16,
                 'h40 + k % 16);
    if (writes.size() - nw == 48)
      for (int k = 0; k < 48; k++) chk_wr(nw + k, t, 9 + k, 'h40 + k % 16);
    if (dones.size() - nd == 1) chk("s2_done_cycle", dones[nd] - t, 57);

    // Scenario 3: R=2 L=2 through LOOP_WAIT
    mark();
    run_tile(2, 2, 1'b1, 1000, 0, 1000, 1000, 28, t);
    chk("s3_beats", beats.size() - nb, 4);
    chk("s3_writes", writes.size() - nw, 4);
    chk("s3_dones", dones.size() - nd, 1);
    offs = '{1, 2, 11, 12};
    if (beats.size() - nb == 4)
      for (int i = 0; i < 4; i++)
        chk_beat(nb + i, t, offs[i], 'h10 + i, 'h20 + i / 2, i < 2, i < 2, 1'b0, i >= 2,
                 'h40 + i % 2);
    offs = '{9, 10, 19, 20};
    if (writes.size() - nw == 4)
      for (int i = 0; i < 4; i++) chk_wr(nw + i, t, offs[i], 'h40 + i % 2);
    if (dones.size() - nd == 1) chk("s3_done_cycle", dones[nd] - t, 21);

    // Scenario 4: R=4 L=1 with a 3-cycle stall after beat 2
    mark();
    run_tile(4, 1, 1'b1, 3, 3, 1000, 1000, 22, t);
    chk("s4_beats", beats.size() - nb, 4);
    chk("s4_writes", writes.size() - nw, 4);
    chk("s4_dones", dones.size() - nd, 1);
    offs = '{1, 2, 6, 7};
    if (beats.size() - nb == 4)
      for (int i = 0; i < 4; i++)
        chk_beat(nb + i, t, offs[i], 'h10 + i, 'h20, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    offs = '{9, 10, 14, 15};
    if (writes.size() - nw == 4)
      for (int i = 0; i < 4; i++) chk_wr(nw + i, t, offs[i], 'h40 + i);
    if (dones.size() - nd == 1) chk("s4_done_cycle", dones[nd] - t, 16);
    chk("s4_stray", stray_cnt - sc, 0);

    // Scenario 5: zero rows, then zero loops
    mark();
    run_tile(0, 3, 1'b1, 1000, 0, 1000, 1000, 5, t);
    chk("s5_beats", beats.size() - nb, 0);
    chk("s5_writes", writes.size() - nw, 0);
    chk("s5_dones", dones.size() - nd, 1);
    if (dones.size() - nd == 1) chk("s5_done_cycle", dones[nd] - t, 1);
    chk("s5_busy_cycles", busy_cnt - bc, 1);
    mark();
    run_tile(4, 0, 1'b1, 1000, 0, 1000, 1000, 5, t);
    chk("s5b_beats", beats.size() - nb, 0);
    chk("s5b_dones", dones.size() - nd, 1);
    if (dones.size() - nd == 1) chk("s5b_done_cycle", dones[nd] - t, 1);

    // Scenario 6: second start while busy is ignored
    mark();
    run_tile(4, 1, 1'b1, 1000, 0, 2, 1000, 22, t);
    check_scenario1("s6");

    // Scenario 7: reset during beat 3 abandons the tile
    mark();
    run_tile(4, 1, 1'b1, 1000, 0, 1000, 3, 22, t);
    chk("s7_beats", beats.size() - nb, 2);
    chk("s7_writes", writes.size() - nw, 0);
    chk("s7_dones", dones.size() - nd, 0);
    chk("s7_active_in_reset", rst_active - ra, 0);
    chk("s7_busy_after", {31'h0, busy}, 0);

    // Scenario 8: fresh start after reset reproduces scenario 1
    mark();
    run_tile(4, 1, 1'b1, 1000, 0, 1000, 1000, 20, t);
    check_scenario1("s8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Tile sequencer for `systolic_array`. It accepts one tile descriptor per `start` pulse and issues the per-cycle buffer read requests for input activations, weights, bias and partial sums. It tracks each beat through a fixed-latency pipeline model so that `obuf_write_req` and `obuf_write_addr` arrive aligned with the array output. It sits between the layer-level instruction decoder and the array/buffer ports.

## Interface
- `IBUF_ADDR_WIDTH`, 16, activation buffer address width
- `WBUF_ADDR_WIDTH`, 16, weight buffer address width
- `BBUF_ADDR_WIDTH`, 16, bias buffer address width
- `OBUF_ADDR_WIDTH`, 16, output buffer address width
- `CNT_WIDTH`, 16, width of row/loop counts
- `SA_LATENCY`, 8, cycles from a read beat to its array output (≥1)

- `clk`  in  1  clock; single clock domain
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `start`  in  1  one-cycle tile launch; sampled only in IDLE
- `cfg_rows`  in  CNT_WIDTH  output rows per loop (R)
- `cfg_loops`  in  CNT_WIDTH  accumulation loops (L)
- `cfg_bias_en`  in  1  loop 0 seeds with bias (1) or zero (0)
- `cfg_ibuf_base`, `cfg_wbuf_base`, `cfg_bias_base`, `cfg_obuf_base`  in  matching ADDR widths  base addresses
- `stall`  in  1  blocks issue of new beats
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle completion pulse
- `ibuf_read_req` / `ibuf_read_addr`  out  1 / IBUF_ADDR_WIDTH
- `wbuf_read_req` / `wbuf_read_addr`  out  1 / WBUF_ADDR_WIDTH
- `bias_read_req` / `bias_read_addr`  out  1 / BBUF_ADDR_WIDTH
- `bias_prev_sw`  out  1  1 = accumulate onto bias/zero; 0 = accumulate onto obuf partial sum
- `acc_clear`  out  1  zero seed (loop 0, bias disabled)
- `obuf_read_req` / `obuf_read_addr`  out  1 / OBUF_ADDR_WIDTH
- `obuf_write_req` / `obuf_write_addr`  out  1 / OBUF_ADDR_WIDTH

## Operation
- States: IDLE, COMPUTE, LOOP_WAIT, DRAIN, DONE.
- IDLE: on `start`, latch all `cfg_*` and set `busy`.
  - If R=0 or L=0, go to DONE.
  - Otherwise go to COMPUTE with row=0, loop=0, and ibuf pointer = `cfg_ibuf_base`.
- `start` outside IDLE is ignored.
- COMPUTE: every cycle with `stall`=0, issue one beat for (loop, row):
  - `ibuf_read_req`=1, `ibuf_read_addr` = ibuf pointer; the pointer increments once per beat.
  - `wbuf_read_req`=1, `wbuf_read_addr` = `wbuf_base` + loop.
  - loop 0: `bias_prev_sw`=1; `bias_read_req`=`cfg_bias_en` at `bias_read_addr` = `bias_base`; `acc_clear`=!`cfg_bias_en`; `obuf_read_req`=0.
  - loop >0: `bias_prev_sw`=0; `obuf_read_req`=1 at `obuf_read_addr` = `obuf_base` + row.
  - Each beat pushes (valid, `obuf_base`+row) into an SA_LATENCY-deep shift register.
- Stall cycles issue nothing; all request outputs are 0. The shift register keeps advancing.
- Row wrap: after row R−1, row returns to 0 and loop increments.
  - If R < SA_LATENCY and another loop remains, enter LOOP_WAIT until the shift register holds no valid entry, then return to COMPUTE. This guarantees a read-after-write-safe obuf read.
- After the last beat (loop L−1, row R−1), enter DRAIN. DRAIN exits to DONE once the shift register is empty.
- DONE: `done`=1 for one cycle, `busy` falls, return to IDLE.
- `obuf_write_req`/`obuf_write_addr` come from the shift register output.
- All addresses wrap modulo 2^width; no overflow flags.
- Reset values: every output is 0; state is IDLE; all counters and shift-register valids are cleared.
- Reset mid-operation: the tile is abandoned immediately, no `done` is produced, and any in-flight writes are discarded.

## Timing
- `start` at cycle T: the first beat's requests are registered-visible at T+1.
- A beat at cycle t produces `obuf_write_req` at t+SA_LATENCY.
- No stalls and R ≥ SA_LATENCY: beats occupy T+1..T+R·L, the last write is at T+R·L+SA_LATENCY, and `done` is at T+R·L+SA_LATENCY+1.
- LOOP_WAIT: the next loop's first beat lands the cycle after the previous loop's last write.
- R=0 or L=0: `done` at T+1, with no requests issued.
- Each stall cycle during COMPUTE delays `done` by one cycle.
- `busy` is high from T+1 through the `done` cycle inclusive.

## Test plan
- R=4, L=1, bias_en=1, SA_LATENCY=8, bases 0x10/0x20/0x30/0x40, start at T:
  - ibuf 0x10..0x13 at T+1..T+4; wbuf 0x20; bias_read_req at 0x30 ×4; `bias_prev_sw`=1; no obuf reads.
  - writes 0x40..0x43 at T+9..T+12; `done` at T+13.
- R=16, L=3, bias_en=0:
  - `acc_clear` on beats 1–16.
  - `obuf_read_req` on beats 17–48 with addr cycling 0x40..0x4F; wbuf addr 0x20, 0x21, 0x22.
  - `done` at T+57.
- R=2, L=2 (LOOP_WAIT):
  - beats T+1, T+2; writes T+9, T+10.
  - second-loop beats T+11, T+12; writes T+19, T+20; `done` T+21.
- R=4, L=1 with `stall`=1 for 3 cycles after beat 2:
  - no requests during the stall; addresses continue 0x12, 0x13; `done` at T+16.
- cfg_rows=0: `done` at T+1, no request pulses. A second `start` while busy is ignored (exactly one `done`).
- Reset asserted at COMPUTE beat 3:
  - all outputs 0 in the same cycle; no later writes or `done`.
  - after release, a fresh start reproduces scenario 1.
